// File: rtl/tick_counter_pkg.sv
// rtl/tick_counter_pkg.sv - shared constants and helpers for tick_counter_param
package tick_counter_pkg;

  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_HOLD = 1'b1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler spans 0..DIV-1, so it needs clog2(DIV) bits (at least one).
  function automatic int psc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle step enable every DIV running cycles
module tick_gen
  import tick_counter_pkg::*;
#(
  parameter int DIV = 10,
  parameter int PW  = psc_width(DIV)
) (
  input  logic clk50m,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;

  // step is a data-path enable for the counter, not a derived clock.
  assign step = en && (psc_q == PSC_LAST);

  always_comb begin
    psc_d = psc_q;
    if (clr || step) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk50m) begin
    if (rs) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/tick_counter_param.sv
// rtl/tick_counter_param.sv - prescaled up/down counter with load, wrap/saturate and tick/tc pulses
module tick_counter_param
  import tick_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk50m,
  input  logic             rs,
  input  logic             ss,
  input  logic             ud,
  input  logic             sat,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dem,
  output logic             tick,
  output logic             tc
);

  localparam int     DIV  = calc_div(CLK_HZ, TICK_HZ);
  localparam int     PW   = psc_width(DIV);
  localparam longint CEIL = (longint'(1) << WIDTH) - 1;

  generate
    if (DIV < 2 || longint'(MAX_VAL) > CEIL) begin : g_bad_params
      $error("tick_counter_param: need CLK_HZ/TICK_HZ >= 2 and MAX_VAL <= 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic             step;
  logic [WIDTH-1:0] dem_q;
  logic [WIDTH-1:0] dem_d;
  logic             tick_q;
  logic             tick_d;
  logic             tc_q;
  logic             tc_d;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk50m (clk50m),
    .rs     (rs),
    .en     (ss),
    .clr    (ld),
    .step   (step)
  );

  // A load outranks a coincident step: the step is dropped, no pulses.
  always_comb begin
    dem_d  = dem_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (ld) begin
      dem_d = (din > MAX_V) ? MAX_V : din;
    end else if (step) begin
      tick_d = 1'b1;
      if (ud == DIR_UP) begin
        if (dem_q == MAX_V) begin
          tc_d  = 1'b1;
          dem_d = (sat == SAT_HOLD) ? MAX_V : '0;
        end else begin
          dem_d = dem_q + 1'b1;
        end
      end else begin
        if (dem_q == '0) begin
          tc_d  = 1'b1;
          dem_d = (sat == SAT_HOLD) ? '0 : MAX_V;
        end else begin
          dem_d = dem_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50m) begin
    if (rs) begin
      dem_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      dem_q  <= dem_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign dem  = dem_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_tick_counter_param.sv
// tb/tb_tick_counter_param.sv - randomized and directed bench for tick_counter_param
module tb_tick_counter_param;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rs, ss, ud, sat, ld;
  logic [7:0] din;
  logic [7:0] dem_a, dem_b;
  logic       tick_a, tick_b, tc_a, tc_b;

  always #10 clk = ~clk;

  tick_counter_param #(.WIDTH(8), .CLK_HZ(10), .TICK_HZ(1)) dut_a (
    .clk50m(clk), .rs(rs), .ss(ss), .ud(ud), .sat(sat), .ld(ld), .din(din),
    .dem(dem_a), .tick(tick_a), .tc(tc_a)
  );

  tick_counter_param #(.WIDTH(8), .CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(9)) dut_b (
    .clk50m(clk), .rs(rs), .ss(ss), .ud(ud), .sat(sat), .ld(ld), .din(din),
    .dem(dem_b), .tick(tick_b), .tc(tc_b)
  );

  int checks = 0;
  int errors = 0;

  int m_dem_a = 0, m_psc_a = 0, m_dem_b = 0, m_psc_b = 0;
  bit m_tick_a = 0, m_tc_a = 0, m_tick_b = 0, m_tc_b = 0;
  bit chk_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model(input int dem, input int psc, input int max,
                                output int ndem, output int npsc,
                                output bit ntick, output bit ntc);
    ndem = dem; npsc = psc; ntick = 0; ntc = 0;
    if (rs) begin
      ndem = 0; npsc = 0;
    end else if (ld) begin
      ndem = (int'(din) > max) ? max : int'(din);
      npsc = 0;
    end else if (ss) begin
      if (psc == DIV - 1) begin
        npsc  = 0;
        ntick = 1;
        if ((ud && dem == max) || (!ud && dem == 0)) begin
          ntc  = 1;
          ndem = sat ? dem : (ud ? 0 : max);
        end else begin
          ndem = ud ? dem + 1 : dem - 1;
        end
      end else begin
        npsc = psc + 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    int d, p;
    bit t, c;
    model(m_dem_a, m_psc_a, 255, d, p, t, c);
    m_dem_a <= d; m_psc_a <= p; m_tick_a <= t; m_tc_a <= c;
    model(m_dem_b, m_psc_b, 9, d, p, t, c);
    m_dem_b <= d; m_psc_b <= p; m_tick_b <= t; m_tc_b <= c;
    if (rs) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dem_a", dem_a, m_dem_a);
      check("model_tick_a", tick_a, m_tick_a);
      check("model_tc_a", tc_a, m_tc_a);
      check("model_dem_b", dem_b, m_dem_b);
      check("model_tick_b", tick_b, m_tick_b);
      check("model_tc_b", tc_b, m_tc_b);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rs = 1; ss = 0; ud = 1; sat = 0; ld = 0; din = 8'h00;
    cyc(2);
    check("reset_dem", dem_a, 0);
    check("reset_tick", tick_a, 0);
    check("reset_tc", tc_a, 0);

    // Run up from reset: steps land on cycles 10, 20, 30.
    rs = 0; ss = 1; ud = 1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (k % 10 == 0) begin
        check("run_dem", dem_a, k / 10);
        check("run_tick", tick_a, 1);
      end else begin
        check("run_tick_idle", tick_a, 0);
      end
    end

    // Wrap on the MAX_VAL=9 instance.
    ld = 1; din = 8'd9;
    cyc(1);
    ld = 0;
    check("wrap_load", dem_b, 9);
    for (int k = 1; k <= 11; k++) begin
      cyc(1);
      if (k == 10) begin
        check("wrap_dem", dem_b, 0);
        check("wrap_tc", tc_b, 1);
        check("wrap_tick", tick_b, 1);
      end else begin
        check("wrap_tc_idle", tc_b, 0);
      end
    end

    // Saturate at zero counting down.
    sat = 1; ud = 0; ld = 1; din = 8'd0;
    cyc(1);
    ld = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      check("sat_dem", dem_a, 0);
      check("sat_tc", tc_a, (k % 10 == 0) ? 1 : 0);
    end

    // Pause with psc=4 for 7 cycles; next tick 6 cycles after resume.
    sat = 0; ud = 1; ld = 1; din = 8'd20;
    cyc(1);
    ld = 0;
    check("clamp_dem", dem_b, 9);
    check("load_dem", dem_a, 20);
    cyc(4);
    ss = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      check("pause_tick", tick_a, 0);
      check("pause_dem", dem_a, 20);
    end
    ss = 1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check("resume_tick", tick_a, (k == 6) ? 1 : 0);
    end
    check("resume_dem", dem_a, 21);

    // Load coinciding with a step cycle.
    cyc(9);
    ld = 1; din = 8'h55;
    cyc(1);
    ld = 0;
    check("coll_dem", dem_a, 8'h55);
    check("coll_tick", tick_a, 0);
    check("coll_tc", tc_a, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("coll_next_tick", tick_a, (k == 10) ? 1 : 0);
    end
    check("coll_next_dem", dem_a, 8'h56);

    // Reset wins over load mid-count, and over a step cycle.
    cyc(5);
    rs = 1; ld = 1; din = 8'hAA;
    cyc(1);
    rs = 0; ld = 0;
    check("rsprio_dem", dem_a, 0);
    check("rsprio_tick", tick_a, 0);
    check("rsprio_tc", tc_a, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("rsprio_next_tick", tick_a, (k == 10) ? 1 : 0);
    end
    check("rsprio_next_dem", dem_a, 1);
    cyc(9);
    rs = 1;
    cyc(1);
    rs = 0;
    check("rs_on_step_tick", tick_a, 0);
    check("rs_on_step_dem", dem_a, 0);

    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(63) == 0);
      ld  = ($urandom_range(15) == 0);
      ss  = ($urandom_range(3) != 0);
      ud  = 1'($urandom_range(1));
      sat = 1'($urandom_range(1));
      din = 8'($urandom);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
